// File: rtl/vproc_pkg.sv
// Shared types for the vector-core issue stage: unit encoding, dispatcher
// FSM states and the scoreboard entry layout.
package vproc_pkg;

  typedef enum logic [2:0] {
    UNIT_LSU  = 3'd0,
    UNIT_ALU  = 3'd1,
    UNIT_MUL  = 3'd2,
    UNIT_SLD  = 3'd3,
    UNIT_ELEM = 3'd4,
    UNIT_CFG  = 3'd5
  } op_unit;

  typedef enum logic [1:0] {
    DISP_EMPTY,
    DISP_HOLD,
    DISP_DRAIN
  } dispatch_state;

  typedef struct packed {
    logic        valid;
    logic [31:0] wr_mask;
    logic [31:0] rd_mask;
  } sb_entry;

endpackage

// File: rtl/vproc_dispatch_sb.sv
// In-flight instruction scoreboard: one entry per ID, set on dispatch, cleared on done.
// Read masks are only stored when VPROC_DISPATCH_WAR_EN is defined.
module vproc_dispatch_sb
  import vproc_pkg::*;
#(
  parameter int ID_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_en,
  input  logic [ID_W-1:0] alloc_id,
  input  logic [31:0]     alloc_wr,
`ifdef VPROC_DISPATCH_WAR_EN
  input  logic [31:0]     alloc_rd,
  output logic [31:0]     pend_rd,
`endif
  input  logic            clr_en,
  input  logic [ID_W-1:0] clr_id,
  input  logic [ID_W-1:0] chk_id,
  output logic            chk_free,
  output logic [31:0]     pend_wr,
  output logic            full,
  output logic            empty
);

  localparam int DEPTH = 1 << ID_W;

  logic [DEPTH-1:0] valid_q;
  logic [31:0]      wr_q [DEPTH];
`ifdef VPROC_DISPATCH_WAR_EN
  logic [31:0]      rd_q [DEPTH];
`endif

  // Clear first so a dispatch reusing the same ID wins; a done naming a free ID is a no-op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        wr_q[i] <= '0;
`ifdef VPROC_DISPATCH_WAR_EN
        rd_q[i] <= '0;
`endif
      end
    end else begin
      if (clr_en) valid_q[clr_id] <= 1'b0;
      if (alloc_en) begin
        valid_q[alloc_id] <= 1'b1;
        wr_q[alloc_id]    <= alloc_wr;
`ifdef VPROC_DISPATCH_WAR_EN
        rd_q[alloc_id]    <= alloc_rd;
`endif
      end
    end
  end

  always_comb begin
    pend_wr = '0;
`ifdef VPROC_DISPATCH_WAR_EN
    pend_rd = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        pend_wr = pend_wr | wr_q[i];
`ifdef VPROC_DISPATCH_WAR_EN
        pend_rd = pend_rd | rd_q[i];
`endif
      end
    end
  end

  assign chk_free = !valid_q[chk_id];
  assign full     = &valid_q;
  assign empty    = ~|valid_q;

endmodule

// File: rtl/vproc_dispatcher.sv
// Issue-stage dispatcher: single-entry buffer, hazard check against the scoreboard,
// CFG serialisation by pipeline drain. WAR checking enabled by VPROC_DISPATCH_WAR_EN.
module vproc_dispatcher
  import vproc_pkg::*;
#(
  parameter int ID_W     = 3,
  parameter int UNIT_CNT = 5
) (
  input  logic                clk_i,
  input  logic                async_rst_i,
  input  logic                instr_valid_i,
  output logic                instr_ready_o,
  input  logic [2:0]          instr_unit_i,
  input  logic [31:0]         instr_rd_mask_i,
  input  logic [31:0]         instr_wr_mask_i,
  output logic [UNIT_CNT-1:0] unit_valid_o,
  input  logic [UNIT_CNT-1:0] unit_ready_i,
  output logic [ID_W-1:0]     unit_id_o,
  input  logic                done_valid_i,
  input  logic [ID_W-1:0]     done_id_i,
  output logic                cfg_valid_o,
  output logic                busy_o
);

  dispatch_state       state_q, state_d;
  sb_entry             buf_q;
  logic [2:0]          buf_unit_q;
  logic [ID_W-1:0]     buf_id_q;
  logic [ID_W-1:0]     alloc_ptr_q;
  logic [UNIT_CNT-1:0] unit_sel;
  logic [31:0]         pend_wr, pend_rd;
  logic                sb_free, sb_full, sb_empty;
  logic                hazard, dispatch_fire, cfg_fire, load;

  vproc_dispatch_sb #(.ID_W(ID_W)) u_sb (
    .clk      (clk_i),
    .rst      (async_rst_i),
    .alloc_en (dispatch_fire),
    .alloc_id (buf_id_q),
    .alloc_wr (buf_q.wr_mask),
`ifdef VPROC_DISPATCH_WAR_EN
    .alloc_rd (buf_q.rd_mask),
    .pend_rd  (pend_rd),
`endif
    .clr_en   (done_valid_i),
    .clr_id   (done_id_i),
    .chk_id   (alloc_ptr_q),
    .chk_free (sb_free),
    .pend_wr  (pend_wr),
    .full     (sb_full),
    .empty    (sb_empty)
  );

`ifndef VPROC_DISPATCH_WAR_EN
  assign pend_rd = '0;
`endif

  assign unit_sel = UNIT_CNT'(1) << buf_unit_q;
  assign hazard   = |((buf_q.rd_mask | buf_q.wr_mask) & pend_wr) | |(buf_q.wr_mask & pend_rd);

  // A load needs the next ID's scoreboard slot free, even if the buffer is draining this cycle.
  always_comb begin
    state_d       = state_q;
    unit_valid_o  = '0;
    dispatch_fire = 1'b0;
    cfg_fire      = 1'b0;
    case (state_q)
      DISP_HOLD: begin
        if (!hazard) begin
          unit_valid_o  = unit_sel;
          dispatch_fire = |(unit_sel & unit_ready_i);
        end
      end
      DISP_DRAIN: cfg_fire = sb_empty;
      default: ;
    endcase
    instr_ready_o = (!buf_q.valid | dispatch_fire | cfg_fire) & sb_free & !sb_full;
    load          = instr_valid_i & instr_ready_o;
    if (load) state_d = (instr_unit_i == UNIT_CFG) ? DISP_DRAIN : DISP_HOLD;
    else if (dispatch_fire | cfg_fire) state_d = DISP_EMPTY;
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      state_q     <= DISP_EMPTY;
      buf_q       <= '0;
      buf_unit_q  <= '0;
      buf_id_q    <= '0;
      alloc_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        buf_q       <= '{valid: 1'b1, wr_mask: instr_wr_mask_i, rd_mask: instr_rd_mask_i};
        buf_unit_q  <= instr_unit_i;
        buf_id_q    <= alloc_ptr_q;
        alloc_ptr_q <= alloc_ptr_q + ID_W'(1);
      end else if (dispatch_fire | cfg_fire) begin
        buf_q.valid <= 1'b0;
      end
    end
  end

  assign unit_id_o   = buf_id_q;
  assign cfg_valid_o = cfg_fire;
  assign busy_o      = buf_q.valid | !sb_empty;

endmodule

// File: tb/tb_vproc_dispatcher.sv
// Directed self-checking bench for vproc_dispatcher; WAR expectations follow VPROC_DISPATCH_WAR_EN.
module tb_vproc_dispatcher;

  localparam int ID_W     = 3;
  localparam int UNIT_CNT = 5;
  localparam logic [2:0] U_LSU = 3'd0, U_ALU = 3'd1, U_MUL = 3'd2, U_SLD = 3'd3, U_CFG = 3'd5;
`ifdef VPROC_DISPATCH_WAR_EN
  localparam bit WAR_EN = 1'b1;
`else
  localparam bit WAR_EN = 1'b0;
`endif

  logic                clk_i = 1'b0;
  logic                async_rst_i = 1'b0;
  logic                instr_valid_i = 1'b0;
  logic                instr_ready_o;
  logic [2:0]          instr_unit_i = '0;
  logic [31:0]         instr_rd_mask_i = '0;
  logic [31:0]         instr_wr_mask_i = '0;
  logic [UNIT_CNT-1:0] unit_valid_o;
  logic [UNIT_CNT-1:0] unit_ready_i = '1;
  logic [ID_W-1:0]     unit_id_o;
  logic                done_valid_i = 1'b0;
  logic [ID_W-1:0]     done_id_i = '0;
  logic                cfg_valid_o;
  logic                busy_o;

  int checks = 0;
  int errors = 0;

  vproc_dispatcher #(.ID_W(ID_W), .UNIT_CNT(UNIT_CNT)) dut (
    .clk_i           (clk_i),
    .async_rst_i     (async_rst_i),
    .instr_valid_i   (instr_valid_i),
    .instr_ready_o   (instr_ready_o),
    .instr_unit_i    (instr_unit_i),
    .instr_rd_mask_i (instr_rd_mask_i),
    .instr_wr_mask_i (instr_wr_mask_i),
    .unit_valid_o    (unit_valid_o),
    .unit_ready_i    (unit_ready_i),
    .unit_id_o       (unit_id_o),
    .done_valid_i    (done_valid_i),
    .done_id_i       (done_id_i),
    .cfg_valid_o     (cfg_valid_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_instr(input logic v, input logic [2:0] u, input logic [31:0] rd, input logic [31:0] wr);
    instr_valid_i   = v;
    instr_unit_i    = u;
    instr_rd_mask_i = rd;
    instr_wr_mask_i = wr;
  endtask

  task automatic drive_done(input logic v, input logic [ID_W-1:0] id);
    done_valid_i = v;
    done_id_i    = id;
  endtask

  task automatic do_reset();
    async_rst_i = 1'b1;
    drive_instr(1'b0, U_LSU, '0, '0);
    drive_done(1'b0, '0);
    unit_ready_i = '1;
    tick();
    tick();
    async_rst_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (unit_valid_o !== 5'b00000) begin errors++; $display("FAIL reset_unit_valid got %b exp 00000", unit_valid_o); end
    checks++; if (cfg_valid_o !== 1'b0) begin errors++; $display("FAIL reset_cfg_valid got %b exp 0", cfg_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", instr_ready_o); end
  endtask

  task automatic test_stream();
    do_reset();
    drive_instr(1'b1, U_ALU, '0, 32'h2);
    tick();
    drive_instr(1'b1, U_MUL, '0, 32'h4);
    #1;
    checks++; if (unit_valid_o !== 5'b00010 || unit_id_o !== 3'd0) begin errors++; $display("FAIL stream_alu got %b/%0d exp 00010/0", unit_valid_o, unit_id_o); end
    tick();
    drive_instr(1'b0, U_LSU, '0, '0);
    #1;
    checks++; if (unit_valid_o !== 5'b00100 || unit_id_o !== 3'd1) begin errors++; $display("FAIL stream_mul got %b/%0d exp 00100/1", unit_valid_o, unit_id_o); end
    tick();
    checks++; if (unit_valid_o !== 5'b00000 || busy_o !== 1'b1) begin errors++; $display("FAIL stream_inflight got valid %b busy %b exp 00000 1", unit_valid_o, busy_o); end
    drive_done(1'b1, 3'd0);
    tick();
    drive_done(1'b1, 3'd1);
    tick();
    drive_done(1'b0, 3'd0);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL stream_idle_busy got %b exp 0", busy_o); end
  endtask

  task automatic test_raw();
    do_reset();
    drive_instr(1'b1, U_LSU, '0, 32'h300);
    tick();
    drive_instr(1'b1, U_ALU, 32'h200, 32'h1000);
    #1;
    checks++; if (unit_valid_o !== 5'b00001 || unit_id_o !== 3'd0) begin errors++; $display("FAIL raw_lsu got %b/%0d exp 00001/0", unit_valid_o, unit_id_o); end
    tick();
    drive_instr(1'b0, U_LSU, '0, '0);
    #1;
    checks++; if (instr_ready_o !== 1'b0) begin errors++; $display("FAIL raw_ready got %b exp 0", instr_ready_o); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (unit_valid_o !== 5'b00000) begin errors++; $display("FAIL raw_blocked_%0d got %b exp 00000", k, unit_valid_o); end
      tick();
    end
    drive_done(1'b1, 3'd0);
    #1;
    checks++; if (unit_valid_o !== 5'b00000) begin errors++; $display("FAIL raw_done_cycle got %b exp 00000", unit_valid_o); end
    tick();
    drive_done(1'b0, 3'd0);
    #1;
    checks++; if (unit_valid_o !== 5'b00010 || unit_id_o !== 3'd1) begin errors++; $display("FAIL raw_release got %b/%0d exp 00010/1", unit_valid_o, unit_id_o); end
    tick();
    checks++; if (unit_valid_o !== 5'b00000) begin errors++; $display("FAIL raw_after got %b exp 00000", unit_valid_o); end
  endtask

  task automatic test_cfg_drain();
    do_reset();
    drive_instr(1'b1, U_ALU, '0, 32'h2);
    tick();
    drive_instr(1'b1, U_ALU, '0, 32'h4);
    #1;
    checks++; if (unit_valid_o !== 5'b00010 || unit_id_o !== 3'd0) begin errors++; $display("FAIL cfg_alu0 got %b/%0d exp 00010/0", unit_valid_o, unit_id_o); end
    tick();
    drive_instr(1'b1, U_CFG, '0, '0);
    #1;
    checks++; if (unit_valid_o !== 5'b00010 || unit_id_o !== 3'd1) begin errors++; $display("FAIL cfg_alu1 got %b/%0d exp 00010/1", unit_valid_o, unit_id_o); end
    tick();
    drive_instr(1'b1, U_ALU, '0, 32'h8);
    drive_done(1'b1, 3'd0);
    #1;
    checks++; if (cfg_valid_o !== 1'b0 || instr_ready_o !== 1'b0) begin errors++; $display("FAIL cfg_wait0 got cfg %b ready %b exp 0 0", cfg_valid_o, instr_ready_o); end
    tick();
    drive_done(1'b1, 3'd1);
    #1;
    checks++; if (cfg_valid_o !== 1'b0 || instr_ready_o !== 1'b0) begin errors++; $display("FAIL cfg_wait1 got cfg %b ready %b exp 0 0", cfg_valid_o, instr_ready_o); end
    tick();
    drive_done(1'b0, 3'd0);
    #1;
    checks++; if (cfg_valid_o !== 1'b1 || instr_ready_o !== 1'b1) begin errors++; $display("FAIL cfg_pulse got cfg %b ready %b exp 1 1", cfg_valid_o, instr_ready_o); end
    tick();
    drive_instr(1'b0, U_LSU, '0, '0);
    #1;
    checks++; if (cfg_valid_o !== 1'b0) begin errors++; $display("FAIL cfg_single got %b exp 0", cfg_valid_o); end
    checks++; if (unit_valid_o !== 5'b00010 || unit_id_o !== 3'd3) begin errors++; $display("FAIL cfg_next got %b/%0d exp 00010/3", unit_valid_o, unit_id_o); end
  endtask

  task automatic test_sb_full();
    do_reset();
    drive_instr(1'b1, U_ALU, '0, '0);
    for (int i = 0; i < 9; i++) begin
      #1;
      if (i > 0) begin
        checks++; if (unit_valid_o !== 5'b00010 || unit_id_o !== ID_W'(i - 1)) begin errors++; $display("FAIL full_disp_%0d got %b/%0d exp 00010/%0d", i, unit_valid_o, unit_id_o, i - 1); end
      end
      checks++; if (instr_ready_o !== (i < 8)) begin errors++; $display("FAIL full_ready_%0d got %b exp %b", i, instr_ready_o, (i < 8)); end
      tick();
    end
    #1;
    checks++; if (instr_ready_o !== 1'b0 || unit_valid_o !== 5'b00000) begin errors++; $display("FAIL full_stall got ready %b valid %b exp 0 00000", instr_ready_o, unit_valid_o); end
    drive_done(1'b1, 3'd3);
    tick();
    drive_done(1'b1, 3'd0);
    #1;
    checks++; if (instr_ready_o !== 1'b0) begin errors++; $display("FAIL full_no_skip got %b exp 0", instr_ready_o); end
    tick();
    drive_done(1'b0, 3'd0);
    #1;
    checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL full_freed got %b exp 1", instr_ready_o); end
    tick();
    drive_instr(1'b0, U_LSU, '0, '0);
    #1;
    checks++; if (unit_valid_o !== 5'b00010 || unit_id_o !== 3'd0) begin errors++; $display("FAIL full_wrap_id got %b/%0d exp 00010/0", unit_valid_o, unit_id_o); end
  endtask

  task automatic test_war();
    logic [4:0] exp_first, exp_second;
    exp_first  = WAR_EN ? 5'b00000 : 5'b00010;
    exp_second = WAR_EN ? 5'b00010 : 5'b00000;
    do_reset();
    drive_instr(1'b1, U_SLD, 32'h10, '0);
    tick();
    drive_instr(1'b1, U_ALU, '0, 32'h10);
    #1;
    checks++; if (unit_valid_o !== 5'b01000 || unit_id_o !== 3'd0) begin errors++; $display("FAIL war_sld got %b/%0d exp 01000/0", unit_valid_o, unit_id_o); end
    tick();
    drive_instr(1'b0, U_LSU, '0, '0);
    drive_done(1'b1, 3'd0);
    #1;
    checks++; if (unit_valid_o !== exp_first) begin errors++; $display("FAIL war_first got %b exp %b", unit_valid_o, exp_first); end
    tick();
    drive_done(1'b0, 3'd0);
    #1;
    checks++; if (unit_valid_o !== exp_second) begin errors++; $display("FAIL war_second got %b exp %b", unit_valid_o, exp_second); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_instr(1'b1, U_ALU, '0, 32'h400 << i);
      tick();
    end
    drive_instr(1'b0, U_LSU, '0, '0);
    unit_ready_i = '0;
    #1;
    checks++; if (unit_valid_o !== 5'b00010 || unit_id_o !== 3'd3 || busy_o !== 1'b1) begin errors++; $display("FAIL rstmid_hold got %b/%0d busy %b exp 00010/3 1", unit_valid_o, unit_id_o, busy_o); end
    #2 async_rst_i = 1'b1;
    #1;
    checks++; if (unit_valid_o !== 5'b00000 || busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_drop got valid %b busy %b exp 00000 0", unit_valid_o, busy_o); end
    tick();
    async_rst_i  = 1'b0;
    unit_ready_i = '1;
    drive_done(1'b1, 3'd2);
    tick();
    drive_done(1'b0, 3'd0);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_stale_done got busy %b exp 0", busy_o); end
    drive_instr(1'b1, U_ALU, 32'h1000, 32'h800);
    tick();
    drive_instr(1'b0, U_LSU, '0, '0);
    #1;
    checks++; if (unit_valid_o !== 5'b00010 || unit_id_o !== 3'd0) begin errors++; $display("FAIL rstmid_fresh got %b/%0d exp 00010/0", unit_valid_o, unit_id_o); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_raw();
    test_cfg_drain();
    test_sb_full();
    test_war();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
